// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array feed controller.
package systolic_pkg;

   localparam int DIM_DEFAULT = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/systolic_feed_ctrl.sv
// Sequences one matrix pass: load DIM operand rows, skew them through the array,
// flush the array, then pulse done.
module systolic_feed_ctrl
   import systolic_pkg::*;
#(
   parameter int DIM       = DIM_DEFAULT,
   parameter int DRAIN_CYC = 2*DIM-2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   hold,
   input  logic                   row_valid,
   output logic                   row_ready,
   output logic                   mem_wren,
   output logic                   mem_en,
   output logic [$clog2(DIM)-1:0] mem_row,
   output logic                   mac_en,
   output logic                   mac_clr,
   output logic                   busy,
   output logic                   done
);

   localparam int ROW_W  = $clog2(DIM);
   localparam int PH_MAX = max_int(DIM-1, DRAIN_CYC);
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX+1) : 1;

   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(DIM-1);
   localparam logic [PH_W-1:0]  FEED_LAST  = PH_W'(DIM-2);
   localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'(DRAIN_CYC-1);

   state_t           state_q;
   logic [ROW_W-1:0] row_q;
   logic [PH_W-1:0]  phase_q;
   logic             first_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         phase_q <= '0;
         first_q <= 1'b0;
      end else if (abort && state_q != ST_IDLE) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         phase_q <= '0;
         first_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_LOAD;
                  first_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               // mac_clr only marks the opening LOAD cycle, stalled or not
               first_q <= 1'b0;
               if (row_valid) begin
                  if (row_q == ROW_LAST) begin
                     row_q   <= '0;
                     state_q <= ST_FEED;
                  end else begin
                     row_q <= row_q + ROW_W'(1);
                  end
               end
            end
            ST_FEED: begin
               if (!hold) begin
                  if (phase_q == FEED_LAST) begin
                     phase_q <= '0;
                     state_q <= ST_DRAIN;
                  end else begin
                     phase_q <= phase_q + PH_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (!hold) begin
                  if (phase_q == DRAIN_LAST) begin
                     phase_q <= '0;
                     state_q <= ST_DONE;
                  end else begin
                     phase_q <= phase_q + PH_W'(1);
                  end
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Handshake outputs decode straight from state so reset clears them at once
   assign row_ready = (state_q == ST_LOAD);
   assign mem_wren  = (state_q == ST_LOAD) && row_valid;
   assign mem_en    = ((state_q == ST_FEED) || (state_q == ST_DRAIN)) && !hold;
   assign mem_row   = row_q;
   assign mac_en    = mem_wren || mem_en;
   assign mac_clr   = (state_q == ST_LOAD) && first_q;
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_FEED) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: directed pass scenarios plus random inputs,
// checked every cycle against a pass-progress reference model.
module tb_systolic_feed_ctrl;

   localparam int DIM       = 8;
   localparam int DRAIN_CYC = 14;
   localparam int N_LOAD    = DIM;
   localparam int N_SHIFT   = (DIM-1) + DRAIN_CYC;
   localparam int P_DONE    = N_LOAD + N_SHIFT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       hold = 1'b0;
   logic       row_valid = 1'b0;
   logic       row_ready, mem_wren, mem_en, mac_en, mac_clr, busy, done;
   logic [2:0] mem_row;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a pass is N_LOAD accepted rows, then N_SHIFT unheld shifts, then done.
   bit m_active = 1'b0;
   int m_prog   = 0;
   bit m_first  = 1'b0;

   int cyc = 0;
   int obs_wren, obs_en, obs_done_cyc, obs_ndone, obs_both;

   systolic_feed_ctrl #(.DIM(DIM), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .hold      (hold),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .mem_wren  (mem_wren),
      .mem_en    (mem_en),
      .mem_row   (mem_row),
      .mac_en    (mac_en),
      .mac_clr   (mac_clr),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] model_outs();
      logic rr, wr, en, clr, bsy, dn;
      logic [2:0] row;
      rr = 0; wr = 0; en = 0; clr = 0; bsy = 0; dn = 0; row = '0;
      if (!rst && m_active) begin
         if (m_prog < N_LOAD) begin
            rr  = 1'b1;
            wr  = row_valid;
            row = 3'(m_prog);
            clr = m_first;
            bsy = 1'b1;
         end else if (m_prog < P_DONE) begin
            en  = !hold;
            bsy = 1'b1;
         end else begin
            dn = 1'b1;
         end
      end
      return {rr, wr, en, row, wr | en, clr, bsy, dn};
   endfunction

   task automatic model_update();
      if (rst) begin
         m_active = 0; m_prog = 0; m_first = 0;
      end else if (!m_active) begin
         if (start) begin
            m_active = 1; m_prog = 0; m_first = 1;
         end
      end else if (abort || m_prog == P_DONE) begin
         m_active = 0; m_prog = 0; m_first = 0;
      end else begin
         m_first = 0;
         if (m_prog < N_LOAD) begin
            if (row_valid) m_prog++;
         end else if (!hold) begin
            m_prog++;
         end
      end
   endtask

   task automatic step();
      logic [9:0] got;
      @(negedge clk);
      got = {row_ready, mem_wren, mem_en, mem_row, mac_en, mac_clr, busy, done};
      chk($sformatf("outs@%0d", cyc), 32'(got), 32'(model_outs()));
      obs_wren += int'(mem_wren);
      obs_en   += int'(mem_en);
      obs_both += int'(mem_wren & mem_en);
      if (done) begin
         obs_ndone++;
         if (obs_done_cyc < 0) obs_done_cyc = cyc;
      end
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic run_scn(input int id, input int ncyc, input int exp_done,
                          input int exp_ndone, input int exp_wr, input int exp_en);
      cyc = 0; obs_wren = 0; obs_en = 0; obs_done_cyc = -1; obs_ndone = 0; obs_both = 0;
      for (int c = 0; c < ncyc; c++) begin
         start     = (c == 0) || (id == 4 && c == 22) || (id == 5 && c == 9) || (id == 6 && c <= 40);
         row_valid = !(id == 2 && c >= 5 && c <= 7);
         hold      = (id == 3 && c >= 12 && c <= 16);
         abort     = (id == 4 && c == 20);
         rst       = (id == 5 && c == 7);
         step();
      end
      chk($sformatf("s%0d_done_cyc", id), 32'(obs_done_cyc), 32'(exp_done));
      chk($sformatf("s%0d_ndone", id),    32'(obs_ndone),    32'(exp_ndone));
      chk($sformatf("s%0d_wren", id),     32'(obs_wren),     32'(exp_wr));
      chk($sformatf("s%0d_en", id),       32'(obs_en),       32'(exp_en));
      chk($sformatf("s%0d_both", id),     32'(obs_both),     32'd0);
      start = 0; row_valid = 0; hold = 0; rst = 0; abort = 1;
      step();
      abort = 0;
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      run_scn(1, 32, 30, 1,  8, 21);
      run_scn(2, 35, 33, 1,  8, 21);
      run_scn(3, 37, 35, 1,  8, 21);
      run_scn(4, 30, -1, 0, 15, 12);
      run_scn(5, 45, 39, 1, 14, 21);
      run_scn(6, 70, 30, 2, 16, 42);

      obs_both = 0;
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         abort     = ($urandom_range(0, 59) == 0);
         start     = ($urandom_range(0, 7) == 0);
         row_valid = ($urandom_range(0, 9) < 7);
         hold      = ($urandom_range(0, 3) == 0);
         step();
      end
      chk("rand_both", 32'(obs_both), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_feed_ctrl.md
SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 SHALL have parameter DIM, default 8, meaning systolic array dimension (rows = columns).
REQ-002 SHALL have parameter DRAIN_CYC, default 2*DIM-2, meaning array flush cycles after the last operand leaves memory.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  begin one matrix pass; sampled only in IDLE.
REQ-006 SHALL have port abort  in  1  cancel the current pass.
REQ-007 SHALL have port hold  in  1  freeze FEED/DRAIN progress.
REQ-008 SHALL have port row_valid  in  1  source presents one A row.
REQ-009 SHALL have port row_ready  out  1  controller accepts a row.
REQ-010 SHALL have port mem_wren  out  1  operand-memory row write-with-shift.
REQ-011 SHALL have port mem_en  out  1  operand-memory shift-only.
REQ-012 SHALL have port mem_row  out  $clog2(DIM)  operand-memory row index.
REQ-013 SHALL have port mac_en  out  1  advance the MAC array this cycle.
REQ-014 SHALL have port mac_clr  out  1  clear MAC accumulators (1-cycle pulse).
REQ-015 SHALL have port busy  out  1  pass in progress.
REQ-016 SHALL have port done  out  1  pass complete (1-cycle pulse).

Function
REQ-017 SHALL implement states IDLE, LOAD, FEED, DRAIN, DONE.
REQ-018 IDLE: start=1 -> LOAD next cycle; mac_clr SHALL be 1 in the first LOAD cycle only.
REQ-019 LOAD: row_ready=1; mem_wren = row_valid (combinational); mem_row = row counter; row counter increments on each accepted row.
REQ-020 LOAD with row_valid=0 SHALL assert neither mem_wren nor mem_en, so operand memory and skew hold.
REQ-021 Acceptance of row DIM-1 -> FEED next cycle; row counter returns to 0.
REQ-022 FEED: mem_en=1 for exactly DIM-1 non-held cycles, then -> DRAIN.
REQ-023 DRAIN: mem_en=1 (shifts in zeros) for exactly DRAIN_CYC non-held cycles, then -> DONE.
REQ-024 DONE: done=1 for one cycle, then -> IDLE.
REQ-025 mac_en SHALL equal mem_wren OR mem_en in every cycle.
REQ-026 mem_en and mem_wren SHALL never both be 1.
REQ-027 hold=1 in FEED/DRAIN SHALL force mem_en=0 and mac_en=0 and freeze the phase counter; hold SHALL be ignored in other states.
REQ-028 abort=1 in any non-IDLE state SHALL -> IDLE next cycle with all counters cleared, no done pulse; abort SHALL have priority over hold and start.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 busy SHALL be 1 in LOAD, FEED and DRAIN, and 0 in IDLE and DONE.
REQ-031 The phase counter SHALL be wide enough for max(DIM-1, DRAIN_CYC), with no wrap before the terminal count.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE, all counters 0, and every output 0, including row_ready, mem_row, mac_clr and done.
REQ-033 Reset mid-pass SHALL discard progress, with no done pulse after release.

Structure
REQ-034 A shared package systolic_pkg SHALL hold the state enum type and the default DIM constant.
REQ-035 All logic SHALL reside in this module, with no sub-module; state and counters SHALL be registered; handshake outputs SHALL be combinational from state and inputs.

Verification (DIM=8, DRAIN_CYC=14)
REQ-036 start at cycle 0, row_valid held 1 -> mem_wren cycles 1-8 with mem_row 0..7, mem_en cycles 9-29, done=1 at cycle 30, busy 0 at 31.
REQ-037 row_valid low for 3 cycles after row 3 -> no mem_wren or mem_en during the gap, row 4 written with mem_row=4, done delayed by exactly 3 cycles.
REQ-038 hold=1 for 5 cycles mid-FEED -> mem_en=0 and mac_en=0 during hold, total mem_en count still 21, done delayed 5 cycles.
REQ-039 abort in DRAIN -> IDLE next cycle, no done; a following start gives mac_clr=1 and mem_row=0 on the first write.
REQ-040 rst pulse during LOAD after row 5 -> all outputs 0 at once; the next start reloads from mem_row 0.
REQ-041 start held 1 during a whole pass -> only one pass until IDLE is reached, then the next pass begins the cycle after IDLE; mem_en and mem_wren are never both 1.
